uart_byte_fifo: RTL and testbench

//   Elastic byte buffer between uart_rx and uart_tx in the loopback path.

---
 rtl/uart_byte_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_byte_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Elastic byte buffer between uart_rx and uart_tx. Bytes strobed
//               in by the receiver are stored in a circular FIFO and drained
//               to the transmitter one frame at a time, launching a frame only
//               while the transmitter reports idle.
// Ports       : clk, rst_n (async, active-low)
//               rx_data/rx_valid  - push side (one-cycle strobe)
//               tx_busy           - transmitter in-progress flag
//               tx_data/tx_start  - pop side (tx_start is a one-cycle strobe)
//               count/full/empty  - occupancy, decoded from registered count
//               overflow/ovf_clr  - sticky dropped-push flag and its clear
// Revision    : 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_IDLE = 2'd3
    } state_t;

    logic [7:0]    mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [TW-1:0] timer_q,    timer_d;
    state_t        state_q,    state_d;

    logic          full_w;
    logic          empty_w;
    logic          push_en;
    logic          pop_en;

    always_comb begin
        full_w  = (count_q == CW'(DEPTH));
        empty_w = (count_q == '0);
        // Both tests use the pre-edge occupancy: a same-cycle pop never makes
        // room for a push, and a push into an empty FIFO is never bypassed.
        push_en = rx_valid && !full_w;
        pop_en  = (state_q == S_IDLE) && !empty_w && !tx_busy;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        timer_d    = timer_q;
        state_d    = state_q;

        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            tx_data_d = mem_q[rd_ptr_q];
        end

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped push takes priority over a simultaneous clear.
        if (rx_valid && full_w) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pop_en) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
                timer_d = '0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    // Transmitter never acknowledged: treat byte as sent.
                    if (timer_d == TW'(BUSY_TIMEOUT)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered decode so the strobe is glitch-free and aligned with START.
        tx_start_d = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_byte_fifo
// Description : Self-checking bench for uart_byte_fifo. A queue-based model of
//               the buffer and its frame lifetime predicts every output each
//               cycle; a simple transmitter model drives tx_busy.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_byte_fifo;

    localparam int DEPTH = 16;
    localparam int BT    = 15;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_busy  = 1'b0;
    logic          ovf_clr  = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    always #5 clk = ~clk;

    uart_byte_fifo #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue plus the life of the current frame.
    // ------------------------------------------------------------------
    logic [7:0] m_q [$];
    logic [7:0] m_sent [$];
    logic [7:0] m_tx_data  = 8'h00;
    bit         m_tx_start = 1'b0;
    bit         m_ovf      = 1'b0;
    bit         m_ready    = 1'b1;   // may launch a new frame
    bit         m_fall     = 1'b0;   // frame acknowledged, waiting for end
    int         m_rise     = -1;     // cycles spent waiting for acknowledge
    bit         m_was_full, m_was_empty, m_pop, m_nxt_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_tx_data  = 8'h00;
            m_tx_start = 1'b0;
            m_ovf      = 1'b0;
            m_ready    = 1'b1;
            m_fall     = 1'b0;
            m_rise     = -1;
        end else begin
            m_was_full  = (m_q.size() == DEPTH);
            m_was_empty = (m_q.size() == 0);
            m_pop       = m_ready && !m_was_empty && !tx_busy;
            m_nxt_start = 1'b0;
            if (m_pop) begin
                m_tx_data = m_q.pop_front();
                m_sent.push_back(m_tx_data);
            end
            if (rx_valid && !m_was_full) m_q.push_back(rx_data);
            if (rx_valid && m_was_full) m_ovf = 1'b1;
            else if (ovf_clr)           m_ovf = 1'b0;

            if (m_ready) begin
                if (m_pop) begin
                    m_ready     = 1'b0;
                    m_nxt_start = 1'b1;
                end
            end else if (m_tx_start) begin
                m_rise = 0;
            end else if (m_rise >= 0) begin
                if (tx_busy) begin
                    m_rise = -1;
                    m_fall = 1'b1;
                end else begin
                    m_rise++;
                    if (m_rise == BT) begin
                        m_rise  = -1;
                        m_ready = 1'b1;
                    end
                end
            end else if (m_fall) begin
                if (!tx_busy) begin
                    m_fall  = 1'b0;
                    m_ready = 1'b1;
                end
            end
            m_tx_start = m_nxt_start;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        chk("count",    32'(count),    32'(m_q.size()));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_start", 32'(tx_start), 32'(m_tx_start));
        chk("tx_data",  32'(tx_data),  32'(m_tx_data));
    end

    // ------------------------------------------------------------------
    // Transmitter model: 0 = forced level, 1 = busy tx_len cycles per start,
    // 2 = busy stuck low.
    // ------------------------------------------------------------------
    int         tx_mode  = 1;
    bit         tx_force = 1'b0;
    int         tx_len   = 10;
    int         tx_cnt   = 0;
    int         cyc      = 0;
    logic [7:0] tx_log [$];
    int         start_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
        case (tx_mode)
            0: tx_busy = tx_force;
            1: begin
                if (tx_start)        tx_cnt = tx_len;
                else if (tx_cnt > 0) tx_cnt--;
                tx_busy = (tx_cnt > 0);
            end
            default: begin
                tx_cnt  = 0;
                tx_busy = 1'b0;
            end
        endcase
    end

    task automatic cyc_in(input bit v, input logic [7:0] d, input bit clr);
        @(negedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        ovf_clr  = clr;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 8'h00, 1'b0);
    endtask

    bit saw_ff;

    initial begin
        // Reset state, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Single byte latency.
        cyc_in(1'b1, 8'hA5, 1'b0);           // cycle N
        cyc_in(1'b0, 8'h00, 1'b0);           // cycle N+1
        chk("lat_count_n1",    32'(count),    32'd1);
        chk("lat_start_n1",    32'(tx_start), 32'd0);
        cyc_in(1'b0, 8'h00, 1'b0);           // cycle N+2
        chk("lat_start_n2",    32'(tx_start), 32'd1);
        chk("lat_data_n2",     32'(tx_data),  32'hA5);
        chk("lat_count_n2",    32'(count),    32'd0);
        cyc_in(1'b0, 8'h00, 1'b0);           // cycle N+3
        chk("lat_start_n3",    32'(tx_start), 32'd0);
        idle_cycles(20);

        // Asynchronous reset mid-run.
        tx_mode  = 0;
        tx_force = 1'b1;
        idle_cycles(2);
        for (int i = 0; i < 5; i++) cyc_in(1'b1, 8'(8'h50 + i), 1'b0);
        cyc_in(1'b0, 8'h00, 1'b0);
        chk("fill5_count", 32'(count), 32'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count",    32'(count),    32'd0);
        chk("async_empty",    32'(empty),    32'd1);
        chk("async_tx_start", 32'(tx_start), 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Burst fill while transmitter busy.
        for (int i = 0; i < 16; i++) cyc_in(1'b1, 8'(i), 1'b0);
        cyc_in(1'b0, 8'h00, 1'b0);
        chk("burst_full",  32'(full),  32'd1);
        chk("burst_count", 32'(count), 32'd16);

        // Overflow: drop, clear, and set-wins-over-clear.
        cyc_in(1'b1, 8'hFF, 1'b0);
        cyc_in(1'b0, 8'h00, 1'b0);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd16);
        cyc_in(1'b0, 8'h00, 1'b1);
        cyc_in(1'b0, 8'h00, 1'b0);
        chk("ovf_clr",   32'(overflow), 32'd0);
        cyc_in(1'b1, 8'hFF, 1'b1);
        cyc_in(1'b0, 8'h00, 1'b0);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cyc_in(1'b0, 8'h00, 1'b1);
        cyc_in(1'b0, 8'h00, 1'b0);

        // Drain with a transmitter busy 10 cycles per frame.
        tx_log.delete();
        tx_len  = 10;
        tx_mode = 1;
        for (int i = 0; i < 400 && !(empty && !tx_busy && tx_log.size() >= 16); i++)
            cyc_in(1'b0, 8'h00, 1'b0);
        chk("drain_starts", 32'(tx_log.size()), 32'd16);
        chk("drain_empty",  32'(empty),         32'd1);
        saw_ff = 1'b0;
        for (int i = 0; i < tx_log.size() && i < 16; i++) begin
            chk("drain_order", 32'(tx_log[i]), 32'(i));
            if (tx_log[i] == 8'hFF) saw_ff = 1'b1;
        end
        chk("drain_no_ff", 32'(saw_ff), 32'd0);
        idle_cycles(15);

        // Random stream across pointer wrap with pushes meeting pops.
        tx_len = 3;
        tx_log.delete();
        m_sent.delete();
        for (int n = 0; n < 40; n++) begin
            cyc_in(1'b1, 8'($urandom), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) cyc_in(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 400 && !(empty && !tx_busy && tx_log.size() >= m_sent.size()); i++)
            cyc_in(1'b0, 8'h00, 1'b0);
        idle_cycles(5);
        chk("stream_sent", 32'(tx_log.size()), 32'(m_sent.size()));
        chk("stream_empty", 32'(empty), 32'd1);
        for (int i = 0; i < tx_log.size() && i < m_sent.size(); i++)
            chk("stream_order", 32'(tx_log[i]), 32'(m_sent[i]));

        // Busy-acknowledge timeout.
        tx_mode = 2;
        idle_cycles(20);
        tx_log.delete();
        start_cyc.delete();
        cyc_in(1'b1, 8'h3C, 1'b0);
        idle_cycles(3);
        cyc_in(1'b1, 8'h77, 1'b0);
        idle_cycles(45);
        chk("tmo_starts", 32'(start_cyc.size()), 32'd2);
        if (start_cyc.size() >= 2 && tx_log.size() >= 2) begin
            chk("tmo_first",   32'(tx_log[0]), 32'h3C);
            chk("tmo_second",  32'(tx_log[1]), 32'h77);
            chk("tmo_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'(BT + 2));
        end
        chk("tmo_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
